// File: rtl/rv32_pkg.sv
// Shared RV32 definitions for the register file, decoder and forwarding unit.
//   XLEN     : architectural register width
//   NUM_REGS : number of architectural integer registers (x0..x31)
//   ADDR_W   : register index width, clog2(NUM_REGS)
//   ZERO_REG : index of the hardwired-zero register x0
package rv32_pkg;

  localparam int unsigned XLEN     = 32;
  localparam int unsigned NUM_REGS = 32;
  localparam int unsigned ADDR_W   = 5;

  typedef logic [ADDR_W-1:0] reg_idx_t;
  typedef logic [XLEN-1:0]   xword_t;

  localparam reg_idx_t ZERO_REG = 5'd0;

endpackage

// File: rtl/rf_word.sv
// One load-enabled storage word with synchronous active-high reset.
//   clk  : clock, rising edge
//   res  : synchronous active-high reset, clears q to zero (dominates load)
//   load : capture d on the next rising edge
//   d    : data in
//   q    : stored word
module rf_word #(
  parameter int unsigned W = 32
) (
  input  logic         clk,
  input  logic         res,
  input  logic         load,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);

  // Reset wins over a coincident load.
  always_ff @(posedge clk) begin
    if (res) begin
      q <= '0;
    end else if (load) begin
      q <= d;
    end
  end

endmodule

// File: rtl/reg_file_2r1w.sv
// RV32 integer register file: 32 x XLEN, two combinational read ports,
// one synchronous write port. x0 has no storage and always reads zero.
//   clk      : clock, rising edge
//   res      : synchronous active-high reset, clears x1..x31
//   rs1_addr : read port 1 index      rs1_data : read port 1 data
//   rs2_addr : read port 2 index      rs2_data : read port 2 data
//   wr_en    : write enable           wr_addr  : write index
//   wr_data  : write data
// Build option: define RF_WRITE_BYPASS_EN to forward a same-cycle write to
// the read ports; otherwise a read-during-write returns the old value.
module reg_file_2r1w
  import rv32_pkg::*;
(
  input  logic              clk,
  input  logic              res,
  input  logic [ADDR_W-1:0] rs1_addr,
  input  logic [ADDR_W-1:0] rs2_addr,
  output logic [XLEN-1:0]   rs1_data,
  output logic [XLEN-1:0]   rs2_data,
  input  logic              wr_en,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [XLEN-1:0]   wr_data
);

  xword_t regs [NUM_REGS];

  // x0 is a constant; writes to index 0 have nowhere to land.
  assign regs[0] = '0;

  // Storage words x1..x31, each loaded only when addressed.
  for (genvar i = 1; i < NUM_REGS; i++) begin : g_word
    logic load;
    assign load = wr_en && (wr_addr == ADDR_W'(i));

    rf_word #(
      .W (XLEN)
    ) u_word (
      .clk  (clk),
      .res  (res),
      .load (load),
      .d    (wr_data),
      .q    (regs[i])
    );
  end

`ifdef RF_WRITE_BYPASS_EN
  logic byp_ok_c;

  // A write that will actually commit this edge; x0 writes never qualify,
  // so x0 reads stay zero even under bypass.
  assign byp_ok_c = wr_en && !res && (wr_addr != ZERO_REG);
`endif

  // Asynchronous read muxes with optional same-cycle forwarding.
  always_comb begin
    rs1_data = regs[rs1_addr];
    rs2_data = regs[rs2_addr];
`ifdef RF_WRITE_BYPASS_EN
    if (byp_ok_c && (rs1_addr == wr_addr)) begin
      rs1_data = wr_data;
    end
    if (byp_ok_c && (rs2_addr == wr_addr)) begin
      rs2_data = wr_data;
    end
`endif
  end

endmodule

// File: tb/tb_reg_file_2r1w.sv
// Directed self-checking bench for reg_file_2r1w with an expected-value queue.
module tb_reg_file_2r1w;
  import rv32_pkg::*;

  logic        clk;
  logic        res;
  logic [4:0]  rs1_addr;
  logic [4:0]  rs2_addr;
  logic [31:0] rs1_data;
  logic [31:0] rs2_data;
  logic        wr_en;
  logic [4:0]  wr_addr;
  logic [31:0] wr_data;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] exp_q [$];

  reg_file_2r1w dut (
    .clk      (clk),
    .res      (res),
    .rs1_addr (rs1_addr),
    .rs2_addr (rs2_addr),
    .rs1_data (rs1_data),
    .rs2_data (rs2_data),
    .wr_en    (wr_en),
    .wr_addr  (wr_addr),
    .wr_data  (wr_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Advance one rising edge and settle 1 time unit after it.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Pop the oldest expectation and compare against an observed value.
  task automatic check(input string tag, input logic [31:0] obs);
    logic [31:0] exp;
    n_tests++;
    if (exp_q.size() == 0) begin
      n_fail++;
      $error("FAIL %s: scoreboard empty, observed %h", tag, obs);
    end else begin
      exp = exp_q.pop_front();
      assert (obs === exp) else begin
        n_fail++;
        $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
    end
  endtask

  // Drive both read addresses, queue their expected data, then compare.
  task automatic rd2(input string tag, input logic [4:0] a1, input logic [31:0] e1,
                     input logic [4:0] a2, input logic [31:0] e2);
    rs1_addr = a1;
    rs2_addr = a2;
    exp_q.push_back(e1);
    exp_q.push_back(e2);
    #1;
    check({tag, "_rs1"}, rs1_data);
    check({tag, "_rs2"}, rs2_data);
  endtask

  // Single write committed on the next edge, then write enable dropped.
  task automatic wr(input logic [4:0] a, input logic [31:0] d);
    wr_en   = 1'b1;
    wr_addr = a;
    wr_data = d;
    tick();
    wr_en   = 1'b0;
  endtask

  initial begin
    logic [31:0] rdw_exp;
    logic [31:0] vi;
    logic [31:0] vj;

    // Reset edge with a competing write to x5.
    res      = 1'b1;
    wr_en    = 1'b1;
    wr_addr  = 5'd5;
    wr_data  = 32'hDEADBEEF;
    rs1_addr = 5'd0;
    rs2_addr = 5'd0;
    #2;
    rd2("x0_in_reset", 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    res   = 1'b0;
    wr_en = 1'b0;
    rd2("reset_clear", 5'd5, 32'h0, 5'd31, 32'h0);

    // Basic back-to-back writes.
    wr(5'd7, 32'h12345678);
    wr(5'd8, 32'hCAFEBABE);
    rd2("basic_rw", 5'd7, 32'h12345678, 5'd8, 32'hCAFEBABE);
    rd2("same_idx", 5'd8, 32'hCAFEBABE, 5'd8, 32'hCAFEBABE);

    // x0 write is dropped, both in the write cycle and afterwards.
    wr_en   = 1'b1;
    wr_addr = 5'd0;
    wr_data = 32'hFFFFFFFF;
    rd2("x0_wr_cycle", 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    wr_en = 1'b0;
    rd2("x0_after", 5'd0, 32'h0, 5'd0, 32'h0);
    tick();
    rd2("x0_later", 5'd0, 32'h0, 5'd7, 32'h12345678);

    // Write enable low must not disturb x3.
    wr(5'd3, 32'h11111111);
    wr_en   = 1'b0;
    wr_addr = 5'd3;
    wr_data = 32'hAAAA5555;
    tick();
    rd2("wr_en_off", 5'd3, 32'h11111111, 5'd0, 32'h0);

    // Read-during-write to x10.
    wr(5'd10, 32'h00000001);
`ifdef RF_WRITE_BYPASS_EN
    rdw_exp = 32'h00000002;
`else
    rdw_exp = 32'h00000001;
`endif
    wr_en   = 1'b1;
    wr_addr = 5'd10;
    wr_data = 32'h00000002;
    rd2("rdw_same_cycle", 5'd10, rdw_exp, 5'd0, 32'h0);
    tick();
    wr_en = 1'b0;
    rd2("rdw_after", 5'd10, 32'h00000002, 5'd10, 32'h00000002);

    // Full sweep: xi = i * 0x01010101.
    for (int i = 1; i < 32; i++) begin
      wr(5'(i), 32'(i) * 32'h01010101);
    end
    for (int i = 1; i < 32; i++) begin
      vi = 32'(i) * 32'h01010101;
      vj = 32'(32 - i) * 32'h01010101;
      rd2($sformatf("sweep_%0d", i), 5'(i), vi, 5'(32 - i), vj);
    end

    // Mid-stream reset, again with a competing write.
    res     = 1'b1;
    wr_en   = 1'b1;
    wr_addr = 5'd12;
    wr_data = 32'h5A5A5A5A;
    tick();
    res   = 1'b0;
    wr_en = 1'b0;
    for (int i = 1; i < 32; i++) begin
      rd2($sformatf("post_reset_%0d", i), 5'(i), 32'h0, 5'(32 - i), 32'h0);
    end

    // Storage usable again after the mid-stream reset.
    wr(5'd12, 32'h0BADF00D);
    rd2("after_reset_wr", 5'd12, 32'h0BADF00D, 5'd13, 32'h0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/reg_file_2r1w.md
Name: reg_file_2r1w

Overview:
- Integer register file for the RV32IC core: 32 x 32-bit architectural registers (x0..x31).
- Read side: two independent read ports feed the decode/execute operands rs1/rs2.
- Write side: one synchronous port driven by the writeback stage.
- x0 is hardwired to zero. Each storage word is a load-enabled 32-bit register with synchronous reset.

Parameters:
- XLEN, 32, register width in bits
- NUM_REGS, 32, number of architectural registers (x0..x31)
- ADDR_W, 5, register index width; must equal clog2(NUM_REGS)

Ports:
- clk  input  1  core clock; all state updates on rising edge
- res  input  1  synchronous active-high reset
- rs1_addr  input  ADDR_W  read port 1 register index
- rs2_addr  input  ADDR_W  read port 2 register index
- rs1_data  output  XLEN  read port 1 data
- rs2_data  output  XLEN  read port 2 data
- wr_en  input  1  write enable from writeback
- wr_addr  input  ADDR_W  write register index
- wr_data  input  XLEN  write data

Behaviour:
- Clock and reset: one clock; reset is synchronous and active-high. Reset is sampled only on the rising edge of clk.
- Reset clears x1..x31 to 0x00000000.
- Reset dominates: if res=1 and wr_en=1 at the same edge, the write is discarded.
- After the reset edge, every read returns 0 until written.
- Reset asserted mid-stream (between writes) clears all previously written values at that edge.
- Write: on posedge clk with res=0 and wr_en=1 and wr_addr!=0, reg[wr_addr] <= wr_data.
  - Visible to reads from the following cycle (1-cycle write latency).
  - wr_en=0 leaves all registers unchanged regardless of wr_addr/wr_data.
- x0: writes with wr_addr=0 are silently dropped. Reads of index 0 always return 0 on both ports, in any cycle including reset.
- Reads are combinational and asynchronous:
  - rs1_data = reg[rs1_addr]; rs2_data = reg[rs2_addr].
  - No read latency; the outputs change in the same cycle as the addresses.
- Both ports may read the same index at once; both return identical data.
- Read-during-write to the same index in the same cycle (without the optional feature): the read returns the OLD value. The new value appears after the edge.
- No X propagation: every register has a defined reset value. Outputs are defined whenever addresses are known.
- No handshake or stall: the block accepts one write per cycle, unconditionally.

Optional Feature:
- Macro: RF_WRITE_BYPASS_EN
- Defined: a same-cycle write is forwarded to the read outputs.
  - Condition: wr_en=1, res=0, wr_addr!=0, and rsN_addr==wr_addr.
  - Result: rsN_data = wr_data combinationally. This removes the WB->ID hazard in the pipeline.
  - x0 reads still return 0 even when wr_addr=0 with wr_en=1.
- Not defined: no forwarding; the old value is returned, as described in Behaviour. Hazard resolution is left to the forwarding unit.

Decomposition:
- Shared package (rv32_pkg), holding:
  - XLEN=32, NUM_REGS=32, ADDR_W=5
  - constant ZERO_REG=5'd0
  - a typedef for a register index (5-bit) and for a data word (32-bit), shared with decoder and forwarding unit
- Sub-module: rf_word, one XLEN-bit register with synchronous active-high reset and load enable.
  - Instantiated for x1..x31 in a generate loop.
  - load = wr_en & (wr_addr==i).
  - x0 has no storage; its value is the constant 0.
- Read muxes and the optional bypass live in the top module.

Test Plan:
- Reset: drive res=1 for 1 edge with wr_en=1, wr_addr=5, wr_data=0xDEADBEEF -> after the edge, rs1_addr=5 and rs2_addr=31 both read 0x00000000.
- Basic write/read: write x7=0x12345678, then x8=0xCAFEBABE on consecutive cycles -> next cycle rs1_addr=7 reads 0x12345678 and rs2_addr=8 reads 0xCAFEBABE.
- x0 protection: write wr_addr=0, wr_data=0xFFFFFFFF -> rs1_addr=0 and rs2_addr=0 read 0x00000000 in that cycle and all later cycles.
- Write enable off: wr_en=0, wr_addr=3, wr_data=0xAAAA5555 after x3=0x11111111 -> x3 still reads 0x11111111.
- Read-during-write: x10=0x00000001, then same cycle wr x10=0x00000002 with rs1_addr=10.
  - Without the macro: reads 0x00000001 during the cycle, 0x00000002 after.
  - With RF_WRITE_BYPASS_EN: reads 0x00000002 in the same cycle.
- Full sweep and mid-stream reset:
  - Write xi=i*0x01010101 for i=1..31, then read all pairs (i, 32-i) -> exact values.
  - Then assert res for one edge -> all 31 registers read 0.
